// File: rtl/parity_tx_pkg.sv
// Shared types and constants for the parity frame transmitter.
package parity_tx_pkg;

    // Frame sequencer states, in line order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Level of the serial line when nothing is being sent.
    localparam logic LINE_IDLE = 1'b1;

    // Clock cycles occupied by one frame: start + data + parity + stop bits.
    function automatic int frame_cycles(input int data_w, input int stop_bits,
                                        input int clks_per_bit);
        return (2 + data_w + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Bit period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick,
    output logic tick_next
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] cnt_n;

    // Tick on the last cycle of a bit; wrap or clear to zero afterwards.
    // tick_next lets the owner register outputs that must line up with
    // the tick one cycle later.
    always_comb begin
        bit_tick  = (clk_cnt == LAST);
        cnt_n     = (clear || bit_tick) ? '0 : clk_cnt + 1'b1;
        tick_next = (cnt_n == LAST);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) clk_cnt <= '0;
        else     clk_cnt <= cnt_n;
    end

endmodule

// File: rtl/parity_frame_tx.sv
// UART-style frame serializer for a data word plus externally generated
// parity, with a parity checker flag. Handshake: a word is taken on any
// rising edge where in_valid && in_ready; in_ready is high only in IDLE,
// and inputs are ignored while a frame is in flight.
module parity_frame_tx
    import parity_tx_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done,
    output logic              parity_err,
    output tx_state_e         state_dbg
);

    localparam int BC_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int BC_W   = (BC_MAX > 1) ? $clog2(BC_MAX) : 1;
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);
    localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);

    tx_state_e         state_q, state_n;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic              par_q, par_n;
    logic              perr_n;
    logic              tx_n, busy_n, ready_n, done_n;
    logic              bit_tick, tick_next;

    // Bit timing is held at zero in IDLE so every frame starts on a clean period.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == IDLE),
        .bit_tick (bit_tick),
        .tick_next(tick_next)
    );

    // Next-state, next-data and next-output logic; outputs are computed
    // from the next state so the registered line changes with the state.
    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        shift_n   = shift_q;
        par_n     = par_q;
        perr_n    = parity_err;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_n   = START;
                    bit_cnt_n = '0;
                    shift_n   = data_in;
                    par_n     = parity_in;
                    perr_n    = parity_in ^ (^data_in);
                end
            end
            START: begin
                if (bit_tick) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_n = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        state_n   = PARITY;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_n   = IDLE;
                        bit_cnt_n = '0;
                        perr_n    = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                bit_cnt_n = '0;
                perr_n    = 1'b0;
            end
        endcase

        tx_n = LINE_IDLE;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = LINE_IDLE;
        endcase

        busy_n  = (state_n != IDLE);
        ready_n = (state_n == IDLE);
        done_n  = (state_n == STOP) && (bit_cnt_n == STOP_LAST) && tick_next;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            parity_err <= 1'b0;
            tx_out     <= LINE_IDLE;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            bit_cnt_q  <= bit_cnt_n;
            shift_q    <= shift_n;
            par_q      <= par_n;
            parity_err <= perr_n;
            tx_out     <= tx_n;
            busy       <= busy_n;
            in_ready   <= ready_n;
            frame_done <= done_n;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: default build plus a one-cycle-per-bit,
// two-stop-bit build.
module tb_parity_frame_tx;
    import parity_tx_pkg::*;

    localparam int F = 28;  // (2+4+1)*4

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] data_in;
    logic       parity_in, in_valid;
    logic       in_ready, tx_out, busy, frame_done, parity_err;
    tx_state_e  state_dbg;

    logic [3:0] f_data;
    logic       f_parity, f_valid;
    logic       f_ready, f_tx, f_busy, f_done, f_perr;
    tx_state_e  f_state;

    int total = 0;
    int bad   = 0;

    parity_frame_tx dut (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_in(parity_in),
        .in_valid(in_valid), .in_ready(in_ready), .tx_out(tx_out), .busy(busy),
        .frame_done(frame_done), .parity_err(parity_err), .state_dbg(state_dbg)
    );

    parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut_fast (
        .clk(clk), .rst(rst), .data_in(f_data), .parity_in(f_parity),
        .in_valid(f_valid), .in_ready(f_ready), .tx_out(f_tx), .busy(f_busy),
        .frame_done(f_done), .parity_err(f_perr), .state_dbg(f_state)
    );

    // Wait (bounded) for in_ready, present a word, and return at the
    // falling edge of the first frame cycle.
    task automatic do_accept(input logic [3:0] d, input logic p, input logic keep);
        int waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        data_in   = d;
        parity_in = p;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    // Check every cycle of a default-build frame, starting at cycle k+1,
    // and the first IDLE cycle k+29 afterwards.
    task automatic check_frame(input logic [3:0] d, input logic p, input logic toggle,
                               input logic [3:0] nd, input logic np);
        logic [6:0] bits;
        logic       perr;
        logic       exp_fd;
        bits = {1'b1, p, d[3], d[2], d[1], d[0], 1'b0};
        perr = p ^ d[0] ^ d[1] ^ d[2] ^ d[3];
        for (int c = 1; c <= F; c++) begin
            exp_fd = (c == F);
            total++;
            if (tx_out !== bits[(c-1)/4]) begin
                bad++;
                $display("FAIL tx_bit c=%0d d=%h: got %b want %b", c, d, tx_out, bits[(c-1)/4]);
            end
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL busy c=%0d: got %b want 1", c, busy);
            end
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL in_ready_busy c=%0d: got %b want 0", c, in_ready);
            end
            total++;
            if (parity_err !== perr) begin
                bad++;
                $display("FAIL parity_err c=%0d: got %b want %b", c, parity_err, perr);
            end
            total++;
            if (frame_done !== exp_fd) begin
                bad++;
                $display("FAIL frame_done c=%0d: got %b want %b", c, frame_done, exp_fd);
            end
            if (toggle) begin
                data_in   = (c == F) ? nd : 4'($urandom);
                parity_in = (c == F) ? np : 1'($urandom);
            end
            @(negedge clk);
        end
        total++;
        if ({in_ready, busy, tx_out, parity_err, frame_done} !== 5'b10100) begin
            bad++;
            $display("FAIL post_idle: ready/busy/tx/perr/done got %b want 10100",
                     {in_ready, busy, tx_out, parity_err, frame_done});
        end
        total++;
        if (state_dbg !== IDLE) begin
            bad++;
            $display("FAIL post_state: got %0d want %0d", state_dbg, IDLE);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({tx_out, in_ready, busy, frame_done, parity_err} !== 5'b11000) begin
            bad++;
            $display("FAIL reset: tx/ready/busy/done/perr got %b want 11000",
                     {tx_out, in_ready, busy, frame_done, parity_err});
        end
        total++;
        if ({f_tx, f_ready, f_busy, f_done, f_perr} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_fast: tx/ready/busy/done/perr got %b want 11000",
                     {f_tx, f_ready, f_busy, f_done, f_perr});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        do_accept(4'b1011, 1'b1, 1'b0);
        check_frame(4'b1011, 1'b1, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        do_accept(4'b0110, 1'b0, 1'b0);
        check_frame(4'b0110, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_parity_err();
        do_accept(4'b0000, 1'b1, 1'b0);
        check_frame(4'b0000, 1'b1, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        do_accept(4'b0111, 1'b0, 1'b0);
        check_frame(4'b0111, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_accept(4'h3, 1'b0, 1'b1);
        // in_valid stays high; data toggles during the frame, then 4'hC.
        check_frame(4'h3, 1'b0, 1'b1, 4'hC, 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_frame(4'hC, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_mid_reset();
        do_accept(4'b1010, 1'b1, 1'b0);
        repeat (13) @(negedge clk);  // cycle k+14, inside d2
        total++;
        if ({tx_out, parity_err, busy} !== 3'b011) begin
            bad++;
            $display("FAIL pre_reset: tx/perr/busy got %b want 011", {tx_out, parity_err, busy});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({tx_out, busy, in_ready, frame_done, parity_err} !== 5'b10100) begin
            bad++;
            $display("FAIL mid_reset: tx/busy/ready/done/perr got %b want 10100",
                     {tx_out, busy, in_ready, frame_done, parity_err});
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            total++;
            if ({frame_done, tx_out, busy} !== 3'b010) begin
                bad++;
                $display("FAIL after_reset c=%0d: done/tx/busy got %b want 010",
                         c, {frame_done, tx_out, busy});
            end
        end
        do_accept(4'b0101, 1'b0, 1'b0);
        check_frame(4'b0101, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_fast_two_stop();
        logic [7:0] line;
        logic       exp_fd;
        int         waited = 0;
        line = 8'b1100_1100;  // bit c-1 is the line in cycle c: 0,0,1,1,0,0,1,1
        while (!f_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (f_ready !== 1'b1) begin
            bad++;
            $display("FAIL fast_accept_wait: in_ready=%b required 1", f_ready);
        end
        f_data   = 4'b0110;
        f_parity = 1'b0;
        f_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        f_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp_fd = (c == 8);
            total++;
            if (f_tx !== line[c-1]) begin
                bad++;
                $display("FAIL fast_tx c=%0d: got %b want %b", c, f_tx, line[c-1]);
            end
            total++;
            if (f_done !== exp_fd || f_busy !== 1'b1) begin
                bad++;
                $display("FAIL fast_done_busy c=%0d: done=%b busy=%b want done=%b busy=1",
                         c, f_done, f_busy, exp_fd);
            end
            @(negedge clk);
        end
        total++;
        if ({f_ready, f_busy, f_tx, f_done, f_perr} !== 5'b10100) begin
            bad++;
            $display("FAIL fast_post: ready/busy/tx/done/perr got %b want 10100",
                     {f_ready, f_busy, f_tx, f_done, f_perr});
        end
    endtask

    initial begin
        rst       = 1'b1;
        data_in   = '0;
        parity_in = 1'b0;
        in_valid  = 1'b0;
        f_data    = '0;
        f_parity  = 1'b0;
        f_valid   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_parity_err();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_mid_reset();
        test_fast_two_stop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Downstream consumer of the 4-bit even-parity generator. It accepts a data nibble and its generated parity bit over a valid/ready handshake and serializes them as a UART-style frame on a single line: start bit, then data LSB-first, then parity, then stop bit(s). It also flags, as a checker, when the supplied parity does not match even parity of the data.

Parameters:
DATA_W, 4, data bits per frame (must be >= 1)
CLKS_PER_BIT, 4, clock cycles each line bit is held (must be >= 1)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
data_in  input  DATA_W  nibble to transmit
parity_in  input  1  parity bit from the generator, transmitted unmodified
in_valid  input  1  data_in/parity_in valid
in_ready  output  1  block can accept a frame (high only in IDLE)
tx_out  output  1  serial line, idle high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse on last cycle of final stop bit
parity_err  output  1  parity_in != XOR of data_in for the frame in progress

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset (any state, including mid-frame): next cycle tx_out=1, in_ready=1, busy=0, frame_done=0, parity_err=0, state=IDLE, counters cleared. A partial frame is discarded with no frame_done.
- All outputs registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1, in_ready=1, busy=0. Accept on a rising edge where in_valid && in_ready. At that edge, latch data_in and parity_in into a shift register, and register parity_err = parity_in ^ (^data_in). Then go to START.
- While busy, in_ready=0 and all input changes are ignored.
- START: tx_out=0 for CLKS_PER_BIT cycles.
- DATA: DATA_W bits, d0 first, each held CLKS_PER_BIT cycles.
- PARITY: tx_out = latched parity for CLKS_PER_BIT cycles.
- STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 only in the final cycle, then return to IDLE.
- If acceptance happens at edge k, tx_out carries the start bit in cycles k+1..k+CLKS_PER_BIT.
- Frame length F = (2+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles. IDLE lasts at least 1 cycle between frames, so back-to-back accepts are F+1 cycles apart.
- Counters:
  - clk_cnt is $clog2(CLKS_PER_BIT) bits (minimum 1). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - bit_cnt counts 0..DATA_W-1 in DATA and 0..STOP_BITS-1 in STOP, clearing on each state change.
  - With CLKS_PER_BIT=1, every bit lasts exactly one cycle.
- busy=1 in START through STOP inclusive.
- parity_err holds its value for the whole frame and clears on return to IDLE.
- A parity mismatch does not alter transmission.

Decomposition:
- Package parity_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP)
  - localparam function frame_cycles(DATA_W, STOP_BITS, CLKS_PER_BIT)
  - the idle line level constant (1'b1)
- One sub-module, bit_timer: parameterised CLKS_PER_BIT counter. It has inputs clk, rst, clear, and asserts bit_tick on the last cycle of each bit period. The FSM advances state/bit_cnt only on bit_tick.

Test Plan:
- Reset: hold rst 2 cycles -> tx_out=1, in_ready=1, busy=0, frame_done=0, parity_err=0.
- Defaults, data_in=4'b1011, parity_in=1, accept at edge k -> tx_out in 4-cycle bits: 0,1,1,0,1,1,1. frame_done pulses at cycle k+28. parity_err=0. in_ready=1 at k+29.
- data_in=4'b0000, parity_in=1 -> parity_err=1 throughout the frame. Line still sends parity slot=1. parity_err=0 after return to IDLE.
- in_valid held high with 4'h3 then 4'hC; data_in toggled during the first frame -> second accept exactly 29 cycles after the first. The first frame bits are unaffected by the toggles.
- rst asserted during data bit d2 -> next cycle tx_out=1, busy=0, in_ready=1, no frame_done. A new frame then transmits correctly.
- CLKS_PER_BIT=1, STOP_BITS=2, data 4'b0110, parity 0 -> 8-cycle frame 0,0,1,1,0,0,1,1. frame_done on cycle 8.
